pixel_mixer: RTL and testbench

- Consumer end of the background and sprite pixel FIFOs.
- Issues pop requests on T-cycle ticks, discards the SCX fine-scroll pixels, and merges each background pixel with the coincident sprite pixel using DMG priority rules.
- Maps the result through BGP/OBP0/OBP1 and streams 2-bit shades with an X coordinate to the LCD interface, then signals end of line to the PPU mode controller.

---
 rtl/ppu_pkg.sv | 28 ++
 rtl/pixel_priority_mux.sv | 54 +++++
 rtl/pixel_mixer.sv | 177 +++++++++++++++++
 tb/tb_pixel_mixer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU pixel-path types: mixer FSM states, LCD shade type and the
// DMG palette lookup used wherever a 2-bit colour index becomes a shade.
package ppu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    DRAW    = 2'd2,
    DONE    = 2'd3
  } mixer_state_t;

  typedef logic [1:0] shade_t;

  localparam int X_MAX_DEFAULT = 160;

  function automatic shade_t palette_map(input logic [7:0] palette, input logic [1:0] idx);
    shade_t shade_v;
    case (idx)
      2'd0:    shade_v = palette[1:0];
      2'd1:    shade_v = palette[3:2];
      2'd2:    shade_v = palette[5:4];
      2'd3:    shade_v = palette[7:6];
      default: shade_v = palette[1:0];
    endcase
    return shade_v;
  endfunction

endpackage

// File: rtl/pixel_priority_mux.sv
// Combinational background/sprite winner select with DMG priority rules,
// followed by the BGP/OBP0/OBP1 palette lookup of the winning pixel.
module pixel_priority_mux
  import ppu_pkg::*;
(
  input  logic [1:0] bg_pixel,
  input  logic       bg_ena,
  input  logic [1:0] sprite_pixel,
  input  logic       sprite_valid,
  input  logic       sprite_palette,
  input  logic       sprite_priority,
  input  logic [7:0] bgp,
  input  logic [7:0] obp0,
  input  logic [7:0] obp1,
  output shade_t     shade,
  output logic       sprite_win
);

  logic [1:0] bi_s;
  logic [7:0] obp_s;

  // Winner select and palette mapping
  always_comb begin
    bi_s       = 2'd0;
    obp_s      = obp0;
    shade      = 2'd0;
    sprite_win = 1'b0;

    if (bg_ena) begin
      bi_s = bg_pixel;
    end else begin
      bi_s = 2'd0;
    end

    if (sprite_palette) begin
      obp_s = obp1;
    end else begin
      obp_s = obp0;
    end

    // A behind-background sprite only loses to a non-zero background index.
    sprite_win = sprite_valid && (sprite_pixel != 2'd0) &&
                 !(sprite_priority && (bi_s != 2'd0));

    if (sprite_win) begin
      shade = palette_map(obp_s, sprite_pixel);
    end else if (bg_ena) begin
      shade = palette_map(bgp, bi_s);
    end else begin
      shade = 2'd0;
    end
  end

endmodule

// File: rtl/pixel_mixer.sv
// Pixel FIFO consumer: pops on T-cycle ticks, drops SCX fine-scroll pixels,
// mixes bg/sprite and streams shades to the LCD. Optional PIXEL_MIXER_STATS_EN.
module pixel_mixer
  import ppu_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEFAULT
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       tclk_in,
  input  logic                       line_start_in,
  input  logic                       stall_in,
  input  logic [7:0]                 SCX_in,
  input  logic                       bg_ena_in,
  input  logic [7:0]                 BGP_in,
  input  logic [7:0]                 OBP0_in,
  input  logic [7:0]                 OBP1_in,
  output logic                       rd_en_out,
  input  logic [1:0]                 bg_pixel_in,
  input  logic                       bg_valid_in,
  input  logic [1:0]                 sprite_pixel_in,
  input  logic                       sprite_valid_in,
  input  logic                       sprite_palette_in,
  input  logic                       sprite_priority_in,
  output logic [1:0]                 lcd_pixel_out,
  output logic                       lcd_valid_out,
  output logic [$clog2(X_MAX)-1:0]   X_out,
  output logic                       line_done_out
`ifdef PIXEL_MIXER_STATS_EN
  ,
  output logic [7:0]                 sprite_count_out
`endif
);

  localparam int              XW     = $clog2(X_MAX);
  localparam logic [XW-1:0]   X_LAST = XW'(X_MAX - 1);

  mixer_state_t   state_r, state_nxt_s;
  logic [2:0]     disc_cnt_r, disc_cnt_nxt_s;
  logic [XW-1:0]  x_cnt_r, x_cnt_nxt_s;
  logic           active_s;
  logic           emit_s;
  shade_t         mix_shade_s;
  logic           sprite_win_s;
  logic [1:0]     lcd_pixel_r;
  logic           lcd_valid_r;
  logic [XW-1:0]  x_out_r;
  logic           line_done_r;
  logic           unused_scx_s;

  assign unused_scx_s = ^SCX_in[7:3];

  pixel_priority_mux u_mux (
    .bg_pixel        (bg_pixel_in),
    .bg_ena          (bg_ena_in),
    .sprite_pixel    (sprite_pixel_in),
    .sprite_valid    (sprite_valid_in),
    .sprite_palette  (sprite_palette_in),
    .sprite_priority (sprite_priority_in),
    .bgp             (BGP_in),
    .obp0            (OBP0_in),
    .obp1            (OBP1_in),
    .shade           (mix_shade_s),
    .sprite_win      (sprite_win_s)
  );

  // Next-state, counter update and pop/emit decode
  always_comb begin
    state_nxt_s    = state_r;
    disc_cnt_nxt_s = disc_cnt_r;
    x_cnt_nxt_s    = x_cnt_r;
    emit_s         = 1'b0;
    active_s       = (state_r == DISCARD) || (state_r == DRAW);

    if (line_start_in) begin
      // Also the abort path when a line is already in progress.
      x_cnt_nxt_s = {XW{1'b0}};
      if (SCX_in[2:0] == 3'd0) begin
        state_nxt_s    = DRAW;
        disc_cnt_nxt_s = 3'd0;
      end else begin
        state_nxt_s    = DISCARD;
        disc_cnt_nxt_s = SCX_in[2:0];
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        DISCARD: begin
          if (bg_valid_in) begin
            if (disc_cnt_r == 3'd1) begin
              disc_cnt_nxt_s = 3'd0;
              state_nxt_s    = DRAW;
            end else begin
              disc_cnt_nxt_s = disc_cnt_r - 3'd1;
            end
          end else begin
            disc_cnt_nxt_s = disc_cnt_r;
          end
        end
        DRAW: begin
          if (bg_valid_in) begin
            emit_s = 1'b1;
            if (x_cnt_r == X_LAST) begin
              x_cnt_nxt_s = {XW{1'b0}};
              state_nxt_s = DONE;
            end else begin
              x_cnt_nxt_s = x_cnt_r + XW'(1);
            end
          end else begin
            x_cnt_nxt_s = x_cnt_r;
          end
        end
        DONE: begin
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  assign rd_en_out = tclk_in && !stall_in && active_s;

  // State, counters and registered LCD outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= IDLE;
      disc_cnt_r  <= 3'd0;
      x_cnt_r     <= {XW{1'b0}};
      lcd_pixel_r <= 2'd0;
      lcd_valid_r <= 1'b0;
      x_out_r     <= {XW{1'b0}};
      line_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      disc_cnt_r  <= disc_cnt_nxt_s;
      x_cnt_r     <= x_cnt_nxt_s;
      lcd_valid_r <= emit_s;
      line_done_r <= (state_r == DONE);
      if (emit_s) begin
        lcd_pixel_r <= mix_shade_s;
        x_out_r     <= x_cnt_r;
      end
    end
  end

  assign lcd_pixel_out = lcd_pixel_r;
  assign lcd_valid_out = lcd_valid_r;
  assign X_out         = x_out_r;
  assign line_done_out = line_done_r;

`ifdef PIXEL_MIXER_STATS_EN
  logic [7:0] sprite_count_r;

  // Per-line count of sprite-won pixels, frozen once the line ends
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sprite_count_r <= 8'd0;
    end else if (line_start_in) begin
      sprite_count_r <= 8'd0;
    end else if (emit_s && sprite_win_s && (sprite_count_r != 8'hFF)) begin
      sprite_count_r <= sprite_count_r + 8'd1;
    end else begin
      sprite_count_r <= sprite_count_r;
    end
  end

  assign sprite_count_out = sprite_count_r;
`else
  logic unused_win_s;
  assign unused_win_s = sprite_win_s;
`endif

endmodule

// File: tb/tb_pixel_mixer.sv
// Directed self-checking bench for pixel_mixer: scroll discard, mixing,
// stall, line abort and reset, with hand-computed expected shades.
module tb_pixel_mixer;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       tclk_in;
  logic       line_start_in;
  logic       stall_in;
  logic [7:0] SCX_in;
  logic       bg_ena_in;
  logic [7:0] BGP_in;
  logic [7:0] OBP0_in;
  logic [7:0] OBP1_in;
  logic       rd_en_out;
  logic [1:0] bg_pixel_in;
  logic       bg_valid_in;
  logic [1:0] sprite_pixel_in;
  logic       sprite_valid_in;
  logic       sprite_palette_in;
  logic       sprite_priority_in;
  logic [1:0] lcd_pixel_out;
  logic       lcd_valid_out;
  logic [7:0] X_out;
  logic       line_done_out;
`ifdef PIXEL_MIXER_STATS_EN
  logic [7:0] sprite_count_out;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int exp_x   = 0;

  pixel_mixer #(.X_MAX(160)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .tclk_in            (tclk_in),
    .line_start_in      (line_start_in),
    .stall_in           (stall_in),
    .SCX_in             (SCX_in),
    .bg_ena_in          (bg_ena_in),
    .BGP_in             (BGP_in),
    .OBP0_in            (OBP0_in),
    .OBP1_in            (OBP1_in),
    .rd_en_out          (rd_en_out),
    .bg_pixel_in        (bg_pixel_in),
    .bg_valid_in        (bg_valid_in),
    .sprite_pixel_in    (sprite_pixel_in),
    .sprite_valid_in    (sprite_valid_in),
    .sprite_palette_in  (sprite_palette_in),
    .sprite_priority_in (sprite_priority_in),
    .lcd_pixel_out      (lcd_pixel_out),
    .lcd_valid_out      (lcd_valid_out),
    .X_out              (X_out),
    .line_done_out      (line_done_out)
`ifdef PIXEL_MIXER_STATS_EN
    ,
    .sprite_count_out   (sprite_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One tick with a valid bg pixel, then one gap cycle.
  task automatic push(input logic [1:0] bg, input logic sv, input logic [1:0] sp,
                      input logic spal, input logic spri, input logic [1:0] exp_shade,
                      input logic exp_emit, input logic exp_last);
    tclk_in            = 1'b1;
    bg_valid_in        = 1'b1;
    bg_pixel_in        = bg;
    sprite_valid_in    = sv;
    sprite_pixel_in    = sp;
    sprite_palette_in  = spal;
    sprite_priority_in = spri;
    #1;
    check("rd_en", rd_en_out, !stall_in);
    step();
    tclk_in         = 1'b0;
    bg_valid_in     = 1'b0;
    sprite_valid_in = 1'b0;
    check("lcd_valid", lcd_valid_out, exp_emit);
    check("line_done_early", line_done_out, 1'b0);
    if (exp_emit) begin
      check("shade", lcd_pixel_out, exp_shade);
      check("x", X_out, exp_x);
      exp_x = (exp_x == 159) ? 0 : exp_x + 1;
    end
    step();
    check("gap_valid", lcd_valid_out, 1'b0);
    check("line_done", line_done_out, exp_last);
  endtask

  task automatic start_line(input logic [2:0] scx);
    SCX_in        = {5'd0, scx};
    line_start_in = 1'b1;
    step();
    line_start_in = 1'b0;
    exp_x         = 0;
    check("start_valid", lcd_valid_out, 1'b0);
    check("start_done", line_done_out, 1'b0);
  endtask

  initial begin
    rst_in = 1'b1; tclk_in = 1'b1; line_start_in = 1'b0; stall_in = 1'b0;
    SCX_in = 8'd0; bg_ena_in = 1'b1; BGP_in = 8'hE4; OBP0_in = 8'hE4; OBP1_in = 8'h1B;
    bg_pixel_in = 2'd0; bg_valid_in = 1'b1; sprite_pixel_in = 2'd0; sprite_valid_in = 1'b0;
    sprite_palette_in = 1'b0; sprite_priority_in = 1'b0;
    repeat (3) step();
    check("rst_rd_en", rd_en_out, 1'b0);
    check("rst_valid", lcd_valid_out, 1'b0);
    check("rst_pixel", lcd_pixel_out, 2'd0);
    check("rst_x", X_out, 8'd0);
    check("rst_done", line_done_out, 1'b0);
    rst_in = 1'b0;
    step();
    check("idle_drop", lcd_valid_out, 1'b0);
    tclk_in = 1'b0; bg_valid_in = 1'b0;
    step();

    // Line 1: no scroll, identity palette
    start_line(3'd0);
    for (int i = 0; i < 160; i++) begin
      push(2'(i % 4), 1'b0, 2'd0, 1'b0, 1'b0, 2'(i % 4), 1'b1, i == 159);
    end
    tclk_in = 1'b1; bg_valid_in = 1'b1;
    #1;
    check("idle_rd_en", rd_en_out, 1'b0);
    step();
    check("post_line_valid", lcd_valid_out, 1'b0);
    check("post_line_done", line_done_out, 1'b0);
    tclk_in = 1'b0; bg_valid_in = 1'b0;

    // Line 2: SCX=5, first five accepted pixels discarded
    start_line(3'd5);
    for (int i = 0; i < 165; i++) begin
      push(2'(i % 4), 1'b0, 2'd0, 1'b0, 1'b0, 2'(i % 4), i >= 5, i == 164);
    end

    // Line 3: priority vectors, stall, abort, reset
    start_line(3'd0);
    push(2'd1, 1'b1, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
    push(2'd1, 1'b1, 2'd2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    push(2'd2, 1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    push(2'd0, 1'b1, 2'd2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    push(2'd3, 1'b1, 2'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    bg_ena_in = 1'b0;
    push(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    push(2'd3, 1'b1, 2'd2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    bg_ena_in = 1'b1;
    push(2'd2, 1'b1, 2'd3, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
    push(2'd1, 1'b0, 2'd3, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    BGP_in = 8'h1B;
    push(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
    BGP_in = 8'hE4;

    stall_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tclk_in = 1'b1;
      #1;
      check("stall_rd_en", rd_en_out, 1'b0);
      step();
      tclk_in = 1'b0;
      check("stall_valid", lcd_valid_out, 1'b0);
      step();
    end
    push(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
    stall_in = 1'b0;
    for (int i = 0; i < 40 && exp_x < 40; i++) begin
      push(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    end
    check("abort_at_x", exp_x, 40);

    start_line(3'd0);
    step();
    check("abort_no_done", line_done_out, 1'b0);
    for (int i = 0; i < 80; i++) begin
      push(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
    end

    rst_in = 1'b1; tclk_in = 1'b1; bg_valid_in = 1'b1; bg_pixel_in = 2'd3;
    step();
    check("midrst_valid", lcd_valid_out, 1'b0);
    check("midrst_pixel", lcd_pixel_out, 2'd0);
    check("midrst_x", X_out, 8'd0);
    check("midrst_done", line_done_out, 1'b0);
    check("midrst_rd_en", rd_en_out, 1'b0);
    rst_in = 1'b0;
    step();
    check("post_rst_drop", lcd_valid_out, 1'b0);
    tclk_in = 1'b0; bg_valid_in = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
